// File: rtl/partial_sum_collector_pkg.sv
// rtl/partial_sum_collector_pkg.sv - shared state encoding, clog2 helper and saturation bounds
package partial_sum_collector_pkg;

   // Collector phases: gather partial sums, then serialize the lanes out
   typedef enum logic {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } state_t;

   // Ceiling log2 for elaboration-time width calculations
   function automatic int pkg_clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Largest representable result, as a 64-bit two's complement constant
   function automatic logic [63:0] sat_max(input int rslt_width, input bit is_unsigned);
      if (is_unsigned) begin
         return (64'd1 << rslt_width) - 64'd1;
      end
      return (64'd1 << (rslt_width - 1)) - 64'd1;
   endfunction

   // Smallest representable result, as a 64-bit two's complement constant
   function automatic logic [63:0] sat_min(input int rslt_width, input bit is_unsigned);
      if (is_unsigned) begin
         return 64'd0;
      end
      return ~((64'd1 << (rslt_width - 1)) - 64'd1);
   endfunction

endpackage

// File: rtl/psum_saturator.sv
// rtl/psum_saturator.sv - clamps a wide accumulator value into the result width
module psum_saturator
   import partial_sum_collector_pkg::*;
#(
   parameter int ACC_WIDTH   = 32,
   parameter int RSLT_WIDTH  = 16,
   parameter int IS_UNSIGNED = 0
) (
   input  logic [ACC_WIDTH-1:0]  i_acc,
   output logic [RSLT_WIDTH-1:0] o_rslt
);

   localparam logic [ACC_WIDTH-1:0] C_MAX = ACC_WIDTH'(sat_max(RSLT_WIDTH, IS_UNSIGNED != 0));
   localparam logic [ACC_WIDTH-1:0] C_MIN = ACC_WIDTH'(sat_min(RSLT_WIDTH, IS_UNSIGNED != 0));

   logic w_over;
   logic w_under;

   // Range detection; unsigned accumulators can never go below zero
   always_comb begin
      w_over  = 1'b0;
      w_under = 1'b0;
      if (IS_UNSIGNED != 0) begin
         w_over = (i_acc > C_MAX);
      end else begin
         w_over  = ($signed(i_acc) > $signed(C_MAX));
         w_under = ($signed(i_acc) < $signed(C_MIN));
      end
   end

   // Select the clamped bound or pass the low bits through untouched
   always_comb begin
      o_rslt = i_acc[RSLT_WIDTH-1:0];
      if (w_over) begin
         o_rslt = C_MAX[RSLT_WIDTH-1:0];
      end else if (w_under) begin
         o_rslt = C_MIN[RSLT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/partial_sum_collector.sv
// rtl/partial_sum_collector.sv - multi-pass partial-sum accumulator with lane serializer
module partial_sum_collector
   import partial_sum_collector_pkg::*;
#(
   parameter int PE_NUMBER_I   = 1,
   parameter int BATCH_SIZE    = 1,
   parameter int RSLT_WIDTH    = 16,
   parameter int ACC_WIDTH     = 32,
   parameter int PASS_WIDTH    = 8,
   parameter int IS_UNSIGNED   = 0,
   parameter int LANE_ID_WIDTH = (pkg_clog2(PE_NUMBER_I * BATCH_SIZE) > 1) ?
                                 pkg_clog2(PE_NUMBER_I * BATCH_SIZE) : 1
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [PASS_WIDTH-1:0]                         cfg_passes,
   input  logic [PE_NUMBER_I*BATCH_SIZE*RSLT_WIDTH-1:0]  s_axis_tdata,
   input  logic [PE_NUMBER_I*BATCH_SIZE-1:0]             s_axis_tvalid,
   output logic [PE_NUMBER_I*BATCH_SIZE-1:0]             s_axis_tready,
   input  logic [PE_NUMBER_I*BATCH_SIZE-1:0]             s_axis_tlast,
   output logic [RSLT_WIDTH-1:0]                         m_axis_tdata,
   output logic                                          m_axis_tvalid,
   input  logic                                          m_axis_tready,
   output logic                                          m_axis_tlast,
   output logic [LANE_ID_WIDTH-1:0]                      m_axis_tid,
   output logic                                          err_unalligned_data,
   output logic                                          busy
);

   localparam int N = PE_NUMBER_I * BATCH_SIZE;

   state_t                   r_state;
   logic [PASS_WIDTH-1:0]    r_pass_cnt;
   logic [PASS_WIDTH-1:0]    r_passes;
   logic [LANE_ID_WIDTH-1:0] r_lane_idx;
   logic [ACC_WIDTH-1:0]     r_acc [N];
   logic                     r_grp_last;
   logic                     r_err;

   logic                     w_all_valid;
   logic                     w_accept;
   logic                     w_first;
   logic                     w_group_end;
   logic                     w_misaligned;
   logic                     w_last_lane;
   logic                     w_draining;
   logic [PASS_WIDTH-1:0]    w_cfg_eff;
   logic [PASS_WIDTH-1:0]    w_passes;
   logic [ACC_WIDTH-1:0]     w_ext [N];
   logic [ACC_WIDTH-1:0]     w_acc_sel;
   logic [RSLT_WIDTH-1:0]    w_sat;

   // Widen each lane to accumulator width (sign- or zero-extended)
   for (genvar k = 0; k < N; k++) begin : g_ext
      logic [RSLT_WIDTH-1:0] w_lane;
      assign w_lane   = s_axis_tdata[k*RSLT_WIDTH +: RSLT_WIDTH];
      assign w_ext[k] = (IS_UNSIGNED != 0) ?
                        {{(ACC_WIDTH-RSLT_WIDTH){1'b0}}, w_lane} :
                        {{(ACC_WIDTH-RSLT_WIDTH){w_lane[RSLT_WIDTH-1]}}, w_lane};
   end

   // Lanes are joined: a beat is taken only when every lane offers one
   assign w_all_valid   = &s_axis_tvalid;
   assign w_draining    = (r_state == DRAIN);
   assign w_accept      = (r_state == COLLECT) && w_all_valid;
   assign s_axis_tready = {N{rst_n && (r_state == COLLECT) && w_all_valid}};

   // A zero pass count behaves as a single pass; the count is frozen after the first beat
   assign w_first      = (r_pass_cnt == '0);
   assign w_cfg_eff    = (cfg_passes == '0) ? PASS_WIDTH'(1) : cfg_passes;
   assign w_passes     = w_first ? w_cfg_eff : r_passes;
   assign w_group_end  = (r_pass_cnt == (w_passes - PASS_WIDTH'(1)));
   assign w_misaligned = (s_axis_tlast != '0) && (s_axis_tlast != '1);
   assign w_last_lane  = (r_lane_idx == LANE_ID_WIDTH'(N - 1));

   // Output side is decoded purely from state flops, so it is stable under backpressure
   assign w_acc_sel           = r_acc[r_lane_idx];
   assign m_axis_tvalid       = w_draining;
   assign m_axis_tdata        = w_draining ? w_sat : '0;
   assign m_axis_tid          = w_draining ? r_lane_idx : '0;
   assign m_axis_tlast        = w_draining && r_grp_last && w_last_lane;
   assign err_unalligned_data = r_err;
   assign busy                = w_draining || (r_pass_cnt != '0);

   psum_saturator #(
      .ACC_WIDTH   (ACC_WIDTH),
      .RSLT_WIDTH  (RSLT_WIDTH),
      .IS_UNSIGNED (IS_UNSIGNED)
   ) u_sat (
      .i_acc  (w_acc_sel),
      .o_rslt (w_sat)
   );

   // Load on the first beat of a group, otherwise add each lane's partial sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            r_acc[k] <= '0;
         end
      end else if (w_accept) begin
         for (int k = 0; k < N; k++) begin
            r_acc[k] <= w_first ? w_ext[k] : (r_acc[k] + w_ext[k]);
         end
      end
   end

   // Group sequencing: count passes while collecting, then walk the lanes out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= COLLECT;
         r_pass_cnt <= '0;
         r_passes   <= '0;
         r_lane_idx <= '0;
         r_grp_last <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            COLLECT: begin
               if (w_accept) begin
                  r_grp_last <= s_axis_tlast[0];
                  if (w_first) begin
                     r_passes <= w_cfg_eff;
                  end
                  if (w_misaligned) begin
                     r_err <= 1'b1;
                  end
                  if (w_group_end) begin
                     r_pass_cnt <= '0;
                     r_state    <= DRAIN;
                  end else begin
                     r_pass_cnt <= r_pass_cnt + PASS_WIDTH'(1);
                  end
               end
            end
            DRAIN: begin
               if (m_axis_tready) begin
                  if (w_last_lane) begin
                     r_lane_idx <= '0;
                     r_state    <= COLLECT;
                  end else begin
                     r_lane_idx <= r_lane_idx + LANE_ID_WIDTH'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_partial_sum_collector.sv
// tb/tb_partial_sum_collector.sv - scoreboard bench for partial_sum_collector (signed and unsigned)
module tb_partial_sum_collector;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  cfg_passes = 8'd0;
   logic [31:0] s_tdata = 32'd0;
   logic [1:0]  s_tvalid = 2'b00;
   logic [1:0]  s_tlast = 2'b00;
   logic        m_tready = 1'b0;

   logic [1:0]  s_tready, s_tready_u;
   logic [15:0] m_tdata, m_tdata_u;
   logic        m_tvalid, m_tvalid_u, m_tlast, m_tlast_u;
   logic        m_tid, m_tid_u, err, err_u, busy, busy_u;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [17:0] exp_s[$];
   logic [17:0] exp_u[$];
   bit          model_err = 1'b0;
   int          rdy_mode = 1;
   logic [15:0] g_d0[16];
   logic [15:0] g_d1[16];
   logic [1:0]  g_last[16];

   partial_sum_collector #(.PE_NUMBER_I(2), .BATCH_SIZE(1), .IS_UNSIGNED(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_passes(cfg_passes),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
      .err_unalligned_data(err), .busy(busy)
   );

   partial_sum_collector #(.PE_NUMBER_I(2), .BATCH_SIZE(1), .IS_UNSIGNED(1)) u_dut_u (
      .clk(clk), .rst_n(rst_n), .cfg_passes(cfg_passes),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_u),
      .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata_u), .m_axis_tvalid(m_tvalid_u),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast_u), .m_axis_tid(m_tid_u),
      .err_unalligned_data(err_u), .busy(busy_u)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] sat_s(input longint v);
      if (v > 32767) return 16'h7fff;
      if (v < -32768) return 16'h8000;
      return v[15:0];
   endfunction

   function automatic logic [15:0] sat_u(input longint v);
      if (v > 65535) return 16'hffff;
      return v[15:0];
   endfunction

   // Downstream ready: random, always on, or held off
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       m_tready = ($urandom_range(3) != 0);
         1:       m_tready = 1'b1;
         default: m_tready = 1'b0;
      endcase
   end

   // Monitor: pops the scoreboard on every output handshake, checks stall stability
   logic [17:0] prev_s, prev_u;
   bit          prev_stall = 1'b0;
   always @(negedge clk) begin
      logic [17:0] e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check("stall_stable", {m_tvalid, m_tlast, m_tid, m_tdata, m_tlast_u, m_tid_u, m_tdata_u},
                  {1'b1, prev_s, prev_u});
         if (m_tvalid) check("drain_s_tready", {s_tready, s_tready_u}, 4'b0000);
         if (m_tvalid && m_tready) begin
            if (exp_s.size() == 0) check("unexpected_out_s", {m_tlast, m_tid, m_tdata}, 18'h3ffff);
            else begin
               e = exp_s.pop_front();
               check("out_signed", {m_tlast, m_tid, m_tdata}, e);
            end
         end
         if (m_tvalid_u && m_tready) begin
            if (exp_u.size() == 0) check("unexpected_out_u", {m_tlast_u, m_tid_u, m_tdata_u}, 18'h3ffff);
            else begin
               e = exp_u.pop_front();
               check("out_unsigned", {m_tlast_u, m_tid_u, m_tdata_u}, e);
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_s = {m_tlast, m_tid, m_tdata};
         prev_u = {m_tlast_u, m_tid_u, m_tdata_u};
      end
   end

   task automatic check_reset_outputs(input string name);
      check(name, {s_tready, s_tready_u, m_tvalid, m_tvalid_u, m_tdata, m_tdata_u, m_tlast, m_tlast_u,
                   m_tid, m_tid_u, err, err_u, busy, busy_u}, 64'd0);
   endtask

   task automatic send_beat(input int b, input int delay1, input bit is_last);
      int n;
      s_tdata = {g_d1[b], g_d0[b]};
      s_tlast = g_last[b];
      if (delay1 > 0) begin
         s_tvalid = 2'b01;
         for (int i = 0; i < delay1; i++) begin
            @(negedge clk);
            check("join_hold", {s_tready, s_tready_u}, 4'b0000);
            @(posedge clk);
            #1;
         end
      end
      s_tvalid = 2'b11;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (s_tready != 2'b11 && n < 500);
      if (s_tready != 2'b11) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: got tready %b expected 11", s_tready);
      end
      @(posedge clk);
      #1;
      s_tvalid = 2'b00;
      if (g_last[b] != 2'b00 && g_last[b] != 2'b11) model_err = 1'b1;
      check("err_flag", {err, err_u}, {model_err, model_err});
      if (is_last) check("valid_after_last", {m_tvalid, busy, m_tvalid_u, busy_u}, 4'b1111);
      else         check("busy_mid_group", {m_tvalid, busy, m_tvalid_u, busy_u}, 4'b0101);
   endtask

   // Reference model: a group's result is the clamped plain sum of its beats per lane
   task automatic run_group(input int cfg, input int delay1, input bit change_cfg);
      int     eff;
      longint ss0, ss1, su0, su1;
      logic   gl;
      eff = (cfg == 0) ? 1 : cfg;
      ss0 = 0; ss1 = 0; su0 = 0; su1 = 0;
      for (int b = 0; b < eff; b++) begin
         ss0 += longint'($signed(g_d0[b]));
         ss1 += longint'($signed(g_d1[b]));
         su0 += longint'(g_d0[b]);
         su1 += longint'(g_d1[b]);
      end
      gl = g_last[eff-1][0];
      exp_s.push_back({1'b0, 1'b0, sat_s(ss0)});
      exp_s.push_back({gl, 1'b1, sat_s(ss1)});
      exp_u.push_back({1'b0, 1'b0, sat_u(su0)});
      exp_u.push_back({gl, 1'b1, sat_u(su1)});
      cfg_passes = cfg[7:0];
      for (int b = 0; b < eff; b++) begin
         send_beat(b, delay1, b == eff - 1);
         if (change_cfg && b == 0) cfg_passes = 8'($urandom_range(0, 7));
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_s.size() != 0 || exp_u.size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (exp_s.size() != 0 || exp_u.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_s.size() + exp_u.size());
      end
      @(posedge clk);
      #1;
      check("busy_idle", {busy, busy_u, m_tvalid, m_tvalid_u}, 4'b0000);
   endtask

   task automatic set_beat(input int b, input logic [15:0] d0, input logic [15:0] d1, input logic [1:0] l);
      g_d0[b] = d0;
      g_d1[b] = d1;
      g_last[b] = l;
   endtask

   initial begin
      #3;
      check_reset_outputs("reset_outputs");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rdy_mode = 1;

      // Basic three-pass group, then the same with lane 1 arriving late
      set_beat(0, 16'd100, -16'sd5, 2'b00);
      set_beat(1, 16'd200, -16'sd5, 2'b00);
      set_beat(2, 16'd300, -16'sd5, 2'b11);
      run_group(3, 0, 1'b0);
      wait_drain();
      run_group(3, 4, 1'b0);
      wait_drain();

      // Saturation on both ends, signed and unsigned
      set_beat(0, 16'd30000, -16'sd30000, 2'b00);
      set_beat(1, 16'd30000, -16'sd30000, 2'b11);
      run_group(2, 0, 1'b0);
      set_beat(0, 16'd60000, 16'd1, 2'b00);
      set_beat(1, 16'd60000, 16'd2, 2'b00);
      run_group(2, 0, 1'b0);
      wait_drain();

      // Downstream backpressure held for five cycles in DRAIN
      rdy_mode = 2;
      set_beat(0, 16'd11, 16'd22, 2'b11);
      run_group(1, 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold", {m_tvalid, m_tid, s_tready}, {1'b1, 1'b0, 2'b00});
      end
      rdy_mode = 1;
      wait_drain();

      // Zero pass count acts as one pass
      set_beat(0, 16'd1234, -16'sd77, 2'b11);
      run_group(0, 0, 1'b0);
      wait_drain();

      // Random groups overlapping each other's drains, random ready and mid-group cfg changes
      rdy_mode = 0;
      for (int g = 0; g < 30; g++) begin
         int c;
         c = $urandom_range(0, 5);
         for (int b = 0; b < 6; b++) begin
            g_d0[b] = ($urandom_range(3) == 0) ? 16'h7ff0 : 16'($urandom);
            g_d1[b] = ($urandom_range(3) == 0) ? 16'h8010 : 16'($urandom);
            g_last[b] = 2'b00;
         end
         g_last[(c == 0) ? 0 : c - 1] = ($urandom_range(1) != 0) ? 2'b11 : 2'b00;
         run_group(c, $urandom_range(0, 2), 1'b1);
      end
      rdy_mode = 1;
      wait_drain();

      // Misaligned tlast: flagged, sticky, still accumulated
      set_beat(0, 16'd5, 16'd6, 2'b01);
      set_beat(1, 16'd7, 16'd8, 2'b00);
      run_group(2, 0, 1'b0);
      wait_drain();
      set_beat(0, 16'd1, 16'd1, 2'b11);
      run_group(1, 0, 1'b0);
      wait_drain();

      // Reset partway through a group discards it and clears the error flag
      set_beat(0, 16'd500, 16'd600, 2'b00);
      cfg_passes = 8'd3;
      send_beat(0, 0, 1'b0);
      rst_n = 1'b0;
      model_err = 1'b0;
      #1;
      check_reset_outputs("reset_mid_group");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_beat(0, 16'd7, 16'd9, 2'b11);
      run_group(1, 0, 1'b0);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/partial_sum_collector.md
Name: partial_sum_collector

Overview:
- Sits at the down edge of the parallelized linear processing array and consumes its PE_NUMBER_I*BATCH_SIZE partial-sum AXI-Streams.
- Accumulates CFG passes of partial sums per lane. This covers reductions whose input dimension exceeds PE_NUMBER_J.
- Saturates each accumulated result to RSLT_WIDTH and serializes all lanes onto one AXI-Stream master for the output writer.

Parameters:
- PE_NUMBER_I, 1, array columns (results per batch per run).
- BATCH_SIZE, 1, array batch planes; lane count N = PE_NUMBER_I*BATCH_SIZE.
- RSLT_WIDTH, 16, width of each incoming partial sum and of the outgoing result.
- ACC_WIDTH, 32, internal accumulator width; must be >= RSLT_WIDTH + PASS_WIDTH.
- PASS_WIDTH, 8, width of the pass-count configuration.
- IS_UNSIGNED, 0, treat data as unsigned (zero-extend, clamp at 0/max).
- LANE_ID_WIDTH, max(1,clog2(N)), width of the output lane index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_passes  in  PASS_WIDTH  beats per accumulation group; sampled at the first beat of each group; 0 is treated as 1.
- s_axis_tdata  in  N*RSLT_WIDTH  partial sums; lane k at [k*RSLT_WIDTH +: RSLT_WIDTH].
- s_axis_tvalid  in  N  per-lane valid.
- s_axis_tready  out  N  per-lane ready.
- s_axis_tlast  in  N  per-lane last.
- m_axis_tdata  out  RSLT_WIDTH  saturated result.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  end of tensor (see Behaviour).
- m_axis_tid  out  LANE_ID_WIDTH  lane index of the current result.
- err_unalligned_data  out  1  sticky lane-misalignment flag.
- busy  out  1  high when a group is partially accumulated or draining.

Behaviour:
- Reset (rst_n low, async): state=COLLECT, pass_cnt=0, lane_idx=0, all accumulators 0, group tlast flag 0. All outputs 0: s_axis_tready, m_axis_tvalid/tdata/tlast/tid, err, busy.
- States are COLLECT and DRAIN.
- COLLECT, join rule: s_axis_tready[k] = &s_axis_tvalid, for every lane. A beat is accepted only when all N lanes are valid in the same cycle; no lane is ever consumed alone.
- COLLECT, accumulate: on an accepted beat with pass_cnt==0, acc[k] <= ext(lane k) and cfg_passes is latched. Otherwise acc[k] <= acc[k] + ext(lane k). ext is sign-extension, or zero-extension when IS_UNSIGNED.
- COLLECT, group tlast: on each beat, group tlast flag <= s_axis_tlast[0].
- COLLECT, misalignment: on an accepted beat where s_axis_tlast is neither all-0 nor all-1, err_unalligned_data sets and holds until reset. The beat is still accumulated.
- COLLECT, group end: when the accepted beat is the last of the group (pass_cnt == latched_passes-1), pass_cnt <= 0 and next state is DRAIN. Otherwise pass_cnt increments.
- DRAIN outputs (registered): m_axis_tvalid=1, m_axis_tid=lane_idx, m_axis_tdata=sat(acc[lane_idx]).
- DRAIN m_axis_tlast = group tlast flag AND lane_idx==N-1.
- DRAIN stall: s_axis_tready=0 in all lanes. m_axis outputs stay stable while tvalid&&!tready.
- DRAIN advance: on handshake, lane_idx increments. The handshake with lane_idx==N-1 returns to COLLECT with lane_idx=0, and m_axis_tvalid drops in that same edge.
- Latency: m_axis_tvalid rises the cycle after the final accepted beat of a group. The group then occupies exactly N output handshakes.
- Throughput: input is stalled during DRAIN. One group costs passes + N cycles minimum.
- sat(), signed: clamp to [-2^(RSLT_WIDTH-1), 2^(RSLT_WIDTH-1)-1].
- sat(), unsigned: clamp to [0, 2^RSLT_WIDTH-1].
- No internal shift; fractional alignment is done upstream.
- busy = (state==DRAIN) || (pass_cnt!=0).
- cfg_passes changes mid-group have no effect until the next group.
- Reset mid-group or mid-DRAIN discards all partial results, with no output beat emitted.

Decomposition:
- Package partial_sum_collector_pkg holds: state encoding (COLLECT=0, DRAIN=1), a clog2 function, and the saturation min/max constants derived from RSLT_WIDTH and IS_UNSIGNED.
- One sub-module, psum_saturator: combinational ACC_WIDTH->RSLT_WIDTH clamp, parameterized by IS_UNSIGNED, instantiated once on the muxed accumulator output.

Test Plan:
- PE_NUMBER_I=2, BATCH_SIZE=1, cfg_passes=3, lane0 beats 100,200,300 and lane1 beats -5,-5,-5, tlast=1 on the third beat, m_axis_tready=1 -> outputs (tid0,600,tlast0) then (tid1,-15,tlast1). Output valid starts 1 cycle after the 3rd accept; busy drops after the last handshake.
- Lane1 tvalid delayed 4 cycles vs lane0 -> no tready to either lane until both are valid; results are identical to the aligned case.
- Signed saturation: cfg_passes=2, lane0 beats 30000,30000 and lane1 beats -30000,-30000 -> 32767 and -32768. IS_UNSIGNED=1 with 60000+60000 -> 65535.
- Backpressure: m_axis_tready low 5 cycles during DRAIN -> tdata/tid/tlast stable; s_axis_tready stays 0; no beat lost or duplicated.
- Misalignment: a beat with s_axis_tlast=2'b01 -> err_unalligned_data rises the next cycle and stays high. Accumulation still completes; only rst_n low clears err.
- Reset: assert rst_n low after 1 of 3 passes -> all outputs 0 immediately. A new group of cfg_passes=1 with lane values 7,9 then outputs exactly 7,9.
